// File: rtl/conv_ctrl_pkg.sv
// Shared types for the convolution tile controller:
// FSM state, latched job configuration and MAC stage-1 bundle.
package conv_ctrl_pkg;

  localparam int DW = 16;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    MAC,
    DRAIN
  } state_t;

  typedef struct packed {
    logic [DW-1:0] w;
    logic [DW-1:0] h;
    logic [DW-1:0] cin;
    logic [DW-1:0] cout;
    logic [DW-1:0] k;
    logic [DW-1:0] tile_w;
  } cfg_t;

  typedef struct packed {
    logic          valid;
    logic          first_tap;
    logic          first_ch;
    logic          last_tap;
    logic          last_ch;
    logic [DW-1:0] x;
    logic [DW-1:0] y;
    logic [DW-1:0] ch_out;
  } stage_t;

  function automatic logic cfg_ok(
    input cfg_t          c,
    input logic [DW-1:0] max_k
  );
    return (c.w != '0) && (c.h != '0) &&
           (c.cin != '0) && (c.cout != '0) &&
           (c.k != '0) && (c.tile_w != '0) &&
           (c.k <= max_k);
  endfunction

endpackage

// File: rtl/loop_counter.sv
// One level of the loop nest: wraps to zero at limit,
// last flags the wrap point so levels can be chained.
module loop_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             arst_n_in,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             last
);

  assign last = (count == limit);

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= last ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/conv_tile_controller.sv
// Runtime-configured conv loop-nest controller with column
// tiling, operand stall handling and a 2-stage MAC control pipe.
import conv_ctrl_pkg::*;

module conv_tile_controller #(
  parameter int DIM_W  = DW,
  parameter int MAX_K  = 7,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              arst_n_in,
  input  logic              start,
  input  logic [DIM_W-1:0]  cfg_w,
  input  logic [DIM_W-1:0]  cfg_h,
  input  logic [DIM_W-1:0]  cfg_cin,
  input  logic [DIM_W-1:0]  cfg_cout,
  input  logic [DIM_W-1:0]  cfg_k,
  input  logic [DIM_W-1:0]  cfg_tile_w,
  output logic              running,
  output logic              cfg_err,
  input  logic              data_ready,
  input  logic              a_valid,
  input  logic              b_valid,
  output logic              a_ready,
  output logic              b_ready,
  output logic              int_mem_re,
  output logic              overlap_cache_re,
  output logic              write_a,
  output logic              write_b,
  output logic [DIM_W-1:0]  kx_out,
  output logic [DIM_W-1:0]  ky_out,
  output logic [DIM_W-1:0]  inch_out,
  output logic [DIM_W-1:0]  outch_out,
  output logic [DIM_W-1:0]  x_out,
  output logic [DIM_W-1:0]  y_out,
  output logic              mac_valid,
  output logic              mac_accumulate_internal,
  output logic              mac_accumulate_with_0,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_read_addr,
  output logic [ADDR_W-1:0] mem_write_addr,
  output logic              output_valid,
  output logic [DIM_W-1:0]  output_x,
  output logic [DIM_W-1:0]  output_y,
  output logic [DIM_W-1:0]  output_ch,
  output logic              tile_done,
  output logic              fsm_done
);

  state_t             state;
  state_t             nxt;
  cfg_t               cfg;
  cfg_t               cfg_in;
  stage_t             s1;
  logic [DIM_W-1:0]   tile_base;
  logic               drain_cnt;
  logic               accept;
  logic               reject;
  logic               drain_end;
  logic               step;
  logic               tile_end;
  logic               last_tile;
  logic [DIM_W:0]     next_base;
  logic [DIM_W-1:0]   rem;
  logic [DIM_W-1:0]   x_span;
  logic [5:0]         en;
  logic [5:0]         last;
  logic [DIM_W-1:0]   cnt [6];
  logic [DIM_W-1:0]   lim [6];

  assign cfg_in = '{w: cfg_w, h: cfg_h, cin: cfg_cin,
                    cout: cfg_cout, k: cfg_k,
                    tile_w: cfg_tile_w};

  assign step     = (state == MAC) & a_valid & b_valid;
  assign tile_end = step & (&last);

  // x wraps early on the last, possibly partial, tile
  assign rem    = cfg.w - tile_base;
  assign x_span = (cfg.tile_w < rem) ? cfg.tile_w : rem;

  assign next_base = {1'b0, tile_base} + {1'b0, cfg.tile_w};
  assign last_tile = next_base >= {1'b0, cfg.w};

  // order: kx, ky, ch_out, ch_in, y, x
  assign lim[0] = cfg.k - 1'b1;
  assign lim[1] = cfg.k - 1'b1;
  assign lim[2] = cfg.cout - 1'b1;
  assign lim[3] = cfg.cin - 1'b1;
  assign lim[4] = cfg.h - 1'b1;
  assign lim[5] = x_span - 1'b1;

  assign en = {step & (&last[4:0]), step & (&last[3:0]),
               step & (&last[2:0]), step & (&last[1:0]),
               step & last[0], step};

  for (genvar i = 0; i < 6; i++) begin : g_cnt
    loop_counter #(.WIDTH(DIM_W)) u_cnt (
      .clk       (clk),
      .arst_n_in (arst_n_in),
      .en        (en[i]),
      .clr       (state == IDLE),
      .limit     (lim[i]),
      .count     (cnt[i]),
      .last      (last[i])
    );
  end

  always_comb begin
    nxt       = state;
    accept    = 1'b0;
    reject    = 1'b0;
    drain_end = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (cfg_ok(cfg_in, DIM_W'(MAX_K))) begin
            accept = 1'b1;
            nxt    = LOAD;
          end else begin
            reject = 1'b1;
          end
        end
      end
      LOAD: if (data_ready) nxt = MAC;
      MAC:  if (tile_end) nxt = DRAIN;
      DRAIN: begin
        if (drain_cnt) begin
          drain_end = 1'b1;
          nxt       = last_tile ? IDLE : LOAD;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      cfg       <= '0;
      tile_base <= '0;
      drain_cnt <= 1'b0;
      cfg_err   <= 1'b0;
      tile_done <= 1'b0;
      fsm_done  <= 1'b0;
    end else begin
      cfg_err   <= reject;
      tile_done <= drain_end;
      fsm_done  <= drain_end & last_tile;
      drain_cnt <= (state == DRAIN) & ~drain_cnt;
      if (accept) begin
        cfg       <= cfg_in;
        tile_base <= '0;
      end else if (drain_end) begin
        tile_base <= next_base[DIM_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      s1             <= '0;
      output_valid   <= 1'b0;
      mem_we         <= 1'b0;
      output_x       <= '0;
      output_y       <= '0;
      output_ch      <= '0;
      mem_write_addr <= '0;
    end else begin
      s1.valid <= step;
      if (step) begin
        s1.first_tap <= (cnt[0] == '0) && (cnt[1] == '0);
        s1.first_ch  <= (cnt[3] == '0);
        s1.last_tap  <= last[0] & last[1];
        s1.last_ch   <= last[3];
        s1.x         <= tile_base + cnt[5];
        s1.y         <= cnt[4];
        s1.ch_out    <= cnt[2];
      end
      output_valid <= s1.valid & s1.last_tap & s1.last_ch;
      mem_we       <= s1.valid & s1.last_tap & ~s1.last_ch;
      if (s1.valid & s1.last_tap & s1.last_ch) begin
        output_x  <= s1.x;
        output_y  <= s1.y;
        output_ch <= s1.ch_out;
      end
      if (s1.valid & s1.last_tap & ~s1.last_ch) begin
        mem_write_addr <= s1.ch_out[ADDR_W-1:0];
      end
    end
  end

  assign running          = (state != IDLE);
  assign a_ready          = (state == MAC);
  assign b_ready          = (state == MAC);
  assign int_mem_re       = step;
  assign overlap_cache_re = step;
  assign write_a          = step;
  assign write_b          = step;

  assign kx_out    = cnt[0];
  assign ky_out    = cnt[1];
  assign outch_out = cnt[2];
  assign inch_out  = cnt[3];
  assign y_out     = cnt[4];
  assign x_out     = tile_base + cnt[5];

  // partial sum fetch is issued with the first tap of ch_in > 0
  assign mem_re = step & (cnt[0] == '0) & (cnt[1] == '0) &
                  (cnt[3] != '0);
  assign mem_read_addr = cnt[2][ADDR_W-1:0];

  assign mac_valid               = s1.valid;
  assign mac_accumulate_internal = s1.valid & ~s1.first_tap;
  assign mac_accumulate_with_0   = s1.valid & s1.first_tap &
                                   s1.first_ch;

endmodule

// File: tb/tb_conv_tile_controller.sv
// Randomized bench for conv_tile_controller against a
// loop-nest reference model built from nested loops.
module tb_conv_tile_controller;

  logic        clk = 1'b0;
  logic        arst_n_in = 1'b0;
  logic        start = 1'b0;
  logic [15:0] cfg_w = '0, cfg_h = '0, cfg_cin = '0;
  logic [15:0] cfg_cout = '0, cfg_k = '0, cfg_tile_w = '0;
  logic        running, cfg_err;
  logic        data_ready = 1'b0, a_valid = 1'b0;
  logic        b_valid = 1'b0;
  logic        a_ready, b_ready;
  logic        int_mem_re, overlap_cache_re, write_a, write_b;
  logic [15:0] kx_out, ky_out, inch_out, outch_out;
  logic [15:0] x_out, y_out;
  logic        mac_valid, mac_accumulate_internal;
  logic        mac_accumulate_with_0;
  logic        mem_re, mem_we;
  logic [9:0]  mem_read_addr, mem_write_addr;
  logic        output_valid;
  logic [15:0] output_x, output_y, output_ch;
  logic        tile_done, fsm_done;

  conv_tile_controller dut (
    .clk(clk), .arst_n_in(arst_n_in), .start(start),
    .cfg_w(cfg_w), .cfg_h(cfg_h), .cfg_cin(cfg_cin),
    .cfg_cout(cfg_cout), .cfg_k(cfg_k),
    .cfg_tile_w(cfg_tile_w),
    .running(running), .cfg_err(cfg_err),
    .data_ready(data_ready),
    .a_valid(a_valid), .b_valid(b_valid),
    .a_ready(a_ready), .b_ready(b_ready),
    .int_mem_re(int_mem_re),
    .overlap_cache_re(overlap_cache_re),
    .write_a(write_a), .write_b(write_b),
    .kx_out(kx_out), .ky_out(ky_out),
    .inch_out(inch_out), .outch_out(outch_out),
    .x_out(x_out), .y_out(y_out),
    .mac_valid(mac_valid),
    .mac_accumulate_internal(mac_accumulate_internal),
    .mac_accumulate_with_0(mac_accumulate_with_0),
    .mem_re(mem_re), .mem_we(mem_we),
    .mem_read_addr(mem_read_addr),
    .mem_write_addr(mem_write_addr),
    .output_valid(output_valid),
    .output_x(output_x), .output_y(output_y),
    .output_ch(output_ch),
    .tile_done(tile_done), .fsm_done(fsm_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] kx, ky, ci, co, x, y;
  } step_t;

  step_t       sq[$];
  logic [47:0] oq[$];
  logic [15:0] wq[$];
  int          n_tiles, n_steps, n_out, n_we;
  int          errors = 0, checks = 0;
  logic        prev_step;
  step_t       prev_e;
  int          st_cnt, mv_cnt, ov_cnt, we_cnt, td_cnt, fd_cnt;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic build(input int cw, ch, cci, cco, ck, ctw);
    step_t e;
    int    n;
    sq.delete(); oq.delete(); wq.delete();
    n_tiles = 0;
    for (int b = 0; b < cw; b += ctw) begin
      n = (cw - b < ctw) ? cw - b : ctw;
      n_tiles++;
      for (int x = 0; x < n; x++)
        for (int y = 0; y < ch; y++)
          for (int c = 0; c < cci; c++)
            for (int o = 0; o < cco; o++)
              for (int ky = 0; ky < ck; ky++)
                for (int kx = 0; kx < ck; kx++) begin
                  e.kx = 16'(kx); e.ky = 16'(ky);
                  e.ci = 16'(c);  e.co = 16'(o);
                  e.x = 16'(b + x); e.y = 16'(y);
                  sq.push_back(e);
                  if (kx == ck - 1 && ky == ck - 1) begin
                    if (c == cci - 1)
                      oq.push_back({16'(b + x), 16'(y), 16'(o)});
                    else
                      wq.push_back(16'(o));
                  end
                end
    end
    n_steps = sq.size();
    n_out = oq.size();
    n_we = wq.size();
  endtask

  task automatic monitor();
    step_t       e;
    logic [15:0] wa;
    logic        pf;
    pf = (prev_e.kx == 0) && (prev_e.ky == 0);
    chk("mac_valid", mac_valid, prev_step);
    if (mac_valid) begin
      mv_cnt++;
      chk("acc_flags",
          {mac_accumulate_internal, mac_accumulate_with_0},
          {!pf, pf && (prev_e.ci == 0)});
    end
    chk("step_gate", int_mem_re && !(a_valid && b_valid), 0);
    chk("strobes", {overlap_cache_re, write_a, write_b},
        {3{int_mem_re}});
    if (int_mem_re) begin
      st_cnt++;
      chk("step_expected", sq.size() > 0, 1);
      if (sq.size() > 0) begin
        e = sq.pop_front();
        chk("fetch", {kx_out, ky_out, inch_out, outch_out,
                      x_out, y_out}, e);
        chk("mem_re", mem_re,
            e.kx == 0 && e.ky == 0 && e.ci != 0);
        if (mem_re) chk("rd_addr", mem_read_addr, e.co[9:0]);
        prev_e = e;
      end
    end else begin
      chk("mem_re_idle", mem_re, 0);
    end
    prev_step = int_mem_re;
    chk("ov_we_excl", output_valid && mem_we, 0);
    if (output_valid) begin
      ov_cnt++;
      chk("out_expected", oq.size() > 0, 1);
      if (oq.size() > 0)
        chk("out_xyc", {output_x, output_y, output_ch},
            oq.pop_front());
    end
    if (mem_we) begin
      we_cnt++;
      chk("we_expected", wq.size() > 0, 1);
      if (wq.size() > 0) begin
        wa = wq.pop_front();
        chk("wr_addr", mem_write_addr, wa[9:0]);
      end
    end
    if (tile_done) td_cnt++;
    if (fsm_done) begin
      fd_cnt++;
      chk("done_with_tile", tile_done, 1);
    end
  endtask

  task automatic run_job(input int cw, ch, cci, cco, ck, ctw,
                         input int mode);
    int cyc = 0;
    build(cw, ch, cci, cco, ck, ctw);
    prev_step = 1'b0;
    prev_e = '0;
    st_cnt = 0; mv_cnt = 0; ov_cnt = 0;
    we_cnt = 0; td_cnt = 0; fd_cnt = 0;
    @(posedge clk); #1;
    cfg_w = 16'(cw); cfg_h = 16'(ch); cfg_cin = 16'(cci);
    cfg_cout = 16'(cco); cfg_k = 16'(ck);
    cfg_tile_w = 16'(ctw);
    start = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
    data_ready = 1'b0;
    @(negedge clk); monitor();
    @(posedge clk); #1;
    start = 1'b0;
    cfg_w = 16'($urandom); cfg_h = 16'($urandom);
    cfg_cin = 16'($urandom); cfg_cout = 16'($urandom);
    cfg_k = 16'($urandom); cfg_tile_w = 16'($urandom);
    while (fd_cnt == 0 && cyc < 20000) begin
      case (mode)
        0: begin a_valid = 1'b1; b_valid = 1'b1; end
        1: begin a_valid = ~a_valid; b_valid = 1'b1; end
        default: begin
          a_valid = ($urandom_range(0, 3) != 0);
          b_valid = ($urandom_range(0, 3) != 0);
        end
      endcase
      data_ready = (mode == 2) ? ($urandom_range(0, 2) == 0)
                               : 1'b1;
      start = (mode == 2) && (cyc < 10) &&
              ($urandom_range(0, 1) == 1);
      @(negedge clk); monitor();
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    repeat (3) begin
      @(negedge clk); monitor();
      @(posedge clk); #1;
    end
    chk("n_done", fd_cnt, 1);
    chk("n_steps", st_cnt, n_steps);
    chk("n_mac", mv_cnt, n_steps);
    chk("n_out", ov_cnt, n_out);
    chk("n_we", we_cnt, n_we);
    chk("n_tiles", td_cnt, n_tiles);
    chk("idle_after", running, 0);
    chk("q_left", sq.size() + oq.size() + wq.size(), 0);
  endtask

  task automatic bad_cfg(input logic [15:0] k, input logic [15:0] w);
    @(posedge clk); #1;
    cfg_w = w; cfg_h = 2; cfg_cin = 2; cfg_cout = 2;
    cfg_k = k; cfg_tile_w = 2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("cfg_err_set", cfg_err, 1);
    chk("cfg_err_norun", running, 0);
    @(posedge clk); #1;
    chk("cfg_err_pulse", cfg_err, 0);
    chk("cfg_err_idle", running, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"},
        {running, cfg_err, a_ready, b_ready, int_mem_re,
         overlap_cache_re, write_a, write_b, mac_valid,
         mac_accumulate_internal, mac_accumulate_with_0,
         mem_re, mem_we, output_valid, tile_done, fsm_done}, 0);
    chk({tag, "_idx"},
        {kx_out, ky_out, inch_out, outch_out, x_out, y_out,
         mem_read_addr, mem_write_addr}, 0);
    chk({tag, "_out"}, {output_x, output_y, output_ch}, 0);
  endtask

  initial begin
    #3;
    chk_all_zero("reset");
    #4 arst_n_in = 1'b1;

    bad_cfg(16'd0, 16'd4);
    bad_cfg(16'd8, 16'd4);
    bad_cfg(16'd3, 16'd0);

    run_job(4, 2, 2, 2, 3, 2, 0);
    run_job(4, 2, 2, 2, 3, 2, 1);
    run_job(5, 1, 1, 1, 1, 2, 0);
    run_job(3, 2, 1, 3, 1, 2, 2);
    run_job(7, 1, 2, 1, 7, 3, 0);
    repeat (3) begin
      run_job($urandom_range(1, 6), $urandom_range(1, 3),
              $urandom_range(1, 3), $urandom_range(1, 3),
              $urandom_range(1, 3), $urandom_range(1, 4), 2);
    end

    @(posedge clk); #1;
    cfg_w = 4; cfg_h = 2; cfg_cin = 2; cfg_cout = 2;
    cfg_k = 3; cfg_tile_w = 2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a_valid = 1'b1; b_valid = 1'b1;
    data_ready = 1'b1;
    repeat (40) @(posedge clk);
    #2;
    chk("pre_rst_mac", mac_valid, 1);
    arst_n_in = 1'b0;
    #1;
    chk_all_zero("mid_rst");
    @(posedge clk); #1;
    chk_all_zero("rst_hold");
    arst_n_in = 1'b1;
    a_valid = 1'b0; b_valid = 1'b0; data_ready = 1'b0;
    run_job(4, 2, 2, 2, 3, 2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv_tile_controller.md
# conv_tile_controller

Parametrised successor controller for the convolution datapath: sequences the loop nest x, y, ch_in, ch_out, ky, kx over a runtime-configured feature map, kernel and column tile size. Sits between the external a/b stream handshake and the MAC unit, partial-sum memory and output marking logic. Adds four things over a fixed-size controller: runtime dimensions, stall-on-invalid data, arbitrary column tiling with a partial last tile, and config error reporting.

## Interface
- DIM_W, 16: width of every loop counter and dimension input
- MAX_K, 7: largest legal kernel size
- ADDR_W, 10: partial-sum memory address width
- clk  in  1  clock
- arst_n_in  in  1  reset, asynchronous, active-low
- start  in  1  begin a job; sampled only in IDLE
- cfg_w, cfg_h, cfg_cin, cfg_cout, cfg_k, cfg_tile_w  in  DIM_W each  feature map width/height, channel counts, kernel size, tile width; latched at accepted start
- running  out  1  state != IDLE
- cfg_err  out  1  one-cycle pulse on a rejected start
- data_ready  in  1  tile data loaded into internal memory
- a_valid, b_valid  in  1  operand stream valid
- a_ready, b_ready  out  1  high in MAC state
- int_mem_re, overlap_cache_re, write_a, write_b  out  1  high on each step
- kx_out, ky_out, inch_out, outch_out, x_out, y_out  out  DIM_W  fetch indices (x_out is absolute)
- mac_valid, mac_accumulate_internal, mac_accumulate_with_0  out  1  MAC control (pipeline stage 1)
- mem_re, mem_we  out  1  partial-sum read/write
- mem_read_addr, mem_write_addr  out  ADDR_W  = ch_out, truncated
- output_valid  out  1  finished output pixel
- output_x, output_y, output_ch  out  DIM_W  coordinates of that pixel
- tile_done, fsm_done  out  1  one-cycle pulses

## Operation
- States: IDLE, LOAD, MAC, DRAIN.
- IDLE -> LOAD on start when the config is legal. A config is illegal if any cfg_* is 0 or cfg_k > MAX_K. An illegal config pulses cfg_err and the block stays in IDLE.
- LOAD: a_ready = b_ready = 0. Move to MAC when data_ready = 1.
- MAC: a step happens when a_valid && b_valid. Without a step, counters and outputs hold and mac_valid goes low next cycle (stall).
- Step:
  - Assert int_mem_re, overlap_cache_re, write_a and write_b.
  - kx increments. Wrap cascades outward in the order kx, ky, ch_out, ch_in, y, x-within-tile. Each counter wraps at its cfg limit − 1.
  - The x limit is min(cfg_tile_w, cfg_w − tile_base), so the last tile may be partial.
- Stage-1 register captures on every step: valid, first_tap (kx = ky = 0), first_ch (ch_in = 0), last_tap, last_ch (ch_in = cfg_cin − 1), x, y, ch_out.
  - mac_valid = stage valid.
  - mac_accumulate_internal = !first_tap.
  - mac_accumulate_with_0 = first_tap && first_ch.
- mem_re = step && first_tap && !first_ch, with mem_read_addr = ch_out. This fetch is issued during the step, so data arrives with mac_valid.
- Stage-2 register: when stage-1 is valid and last_tap:
  - if last_ch: output_valid = 1, and output_x/output_y/output_ch = stage coordinates;
  - otherwise: mem_we = 1, mem_write_addr = stage ch_out.
- End-of-tile step (all counters at limit) moves to DRAIN. DRAIN lasts 2 cycles, then:
  - pulses tile_done;
  - advances tile_base by cfg_tile_w;
  - goes to LOAD, or, if tile_base + cfg_tile_w >= cfg_w, pulses fsm_done together with tile_done and goes to IDLE.
- start outside IDLE is ignored. cfg_* changes after latch are ignored.

## Timing
- Reset: state IDLE. Every counter, the stage registers, tile_base and every output are 0.
- Reset mid-job returns everything to the reset values immediately. No pulse is emitted.
- Latencies:
  - step to mac_valid: 1 cycle;
  - step to output_valid or mem_we: 2 cycles;
  - last step of a tile to tile_done: 3 cycles.
- Back-to-back steps sustain 1 MAC/cycle. A stall inserts exactly one mac_valid = 0 bubble per non-step cycle.
- Counter compare is equality to (cfg − 1) at DIM_W bits. cfg_* = 1 means that counter is always last.

## Structure
- Package conv_ctrl_pkg holds:
  - the state enum;
  - a cfg struct {w, h, cin, cout, k, tile_w};
  - a stage struct {valid, first_tap, first_ch, last_tap, last_ch, x, y, ch_out}.
- Sub-module loop_counter(WIDTH): inputs en, clr, limit; outputs count, last. It is instantiated six times and chained through last.

## Test plan
- W=4, H=2, Cin=2, Cout=2, K=3, tile_w=2, a/b always valid -> 288 mac_valid, 16 output_valid, 16 mem_we, 2 tile_done, 1 fsm_done, return to IDLE.
- Same config, a_valid toggling every cycle -> identical counts and coordinate order; mac_valid duty 50%; no step while a_valid = 0.
- W=5, tile_w=2, H=1, Cin=1, Cout=1, K=1 -> 3 tile_done; the third tile has x_out = 4 only; 5 output_valid with output_x 0..4.
- cfg_k=0 (or cfg_k=8 at MAX_K=7) with start -> cfg_err pulse of 1 cycle; running stays 0.
- Cin=1, K=1 -> mac_accumulate_with_0 on every mac_valid; no mem_re or mem_we ever.
- arst_n_in low mid-MAC for 1 cycle -> all outputs 0 the same cycle; the next start reruns the job with identical output sequence.
